// File: rtl/pulse_pkg.sv
// Shared types and timing constants for the pulse input path.
package pulse_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  localparam int CLK_HZ    = 50000000;
  // One millisecond of clk; the width counter uses the same value for its ms conversion.
  localparam int MS_CYCLES = 50000;

endpackage

// File: rtl/pulse_debouncer_sync.sv
// Plain flop-chain synchroniser for asynchronous pins; no logic between stages.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the pin through the chain; the MSB is the settled copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_debouncer.sv
// Debouncer: synchronises a raw pin, accepts a new level only after it has been
// stable for STABLE_CYCLES+1 cycles, and counts rejected transitions.
module pulse_debouncer
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 20 * MS_CYCLES,
  parameter int CNT_W         = 20,
  parameter int GLITCH_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                raw_in,
  input  logic                clear_glitch,
  output logic                db_level,
  output logic                rise_tick,
  output logic                fall_tick,
  output logic [GLITCH_W-1:0] glitch_count,
  output logic                busy
);

  localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(STABLE_CYCLES - 1);

  logic                sync_in;
  db_state_t           state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                abort;
  logic                rise_q, fall_q;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_in),
    .q   (sync_in)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOW;
    else     state_q <= state_d;
  end

  // Next state and stability timer: a candidate level must survive the whole
  // countdown; any reversion aborts it and is reported as a glitch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    abort   = 1'b0;
    case (state_q)
      LOW: begin
        if (sync_in) begin
          state_d = WAIT_HIGH;
          timer_d = TIMER_LOAD;
        end
      end
      WAIT_HIGH: begin
        if (!sync_in) begin
          state_d = LOW;
          abort   = 1'b1;
        end else if (timer_q == '0) begin
          state_d = HIGH;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      HIGH: begin
        if (!sync_in) begin
          state_d = WAIT_LOW;
          timer_d = TIMER_LOAD;
        end
      end
      WAIT_LOW: begin
        if (sync_in) begin
          state_d = HIGH;
          abort   = 1'b1;
        end else if (timer_q == '0) begin
          state_d = LOW;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      default: state_d = LOW;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    db_level = (state_q == HIGH)      || (state_q == WAIT_LOW);
    busy     = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);
  end

  // Timer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end

  // Glitch counter next value: clear beats a same-cycle abort; saturate at all-ones.
  always_comb begin
    glitch_d = glitch_q;
    if (clear_glitch)                  glitch_d = '0;
    else if (abort && (glitch_q != '1)) glitch_d = glitch_q + GLITCH_W'(1);
  end

  // Glitch counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) glitch_q <= '0;
    else     glitch_q <= glitch_d;
  end

  // Ticks are registered on the accepting transition so they line up with
  // the first cycle of the new db_level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= (state_q == WAIT_HIGH) && (state_d == HIGH);
      fall_q <= (state_q == WAIT_LOW)  && (state_d == LOW);
    end
  end

  assign rise_tick    = rise_q;
  assign fall_tick    = fall_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_pulse_debouncer.sv
// Directed bench for pulse_debouncer with STABLE_CYCLES=4, SYNC_STAGES=2.
// The glitch counter is 8 bits wide here so saturation is reachable quickly.
module tb_pulse_debouncer;

  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          raw_in;
  logic          clear_glitch;
  logic          db_level;
  logic          rise_tick;
  logic          fall_tick;
  logic [GW-1:0] glitch_count;
  logic          busy;

  int checks = 0;
  int errors = 0;

  pulse_debouncer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .CNT_W         (3),
    .GLITCH_W      (GW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raw_in       (raw_in),
    .clear_glitch (clear_glitch),
    .db_level     (db_level),
    .rise_tick    (rise_tick),
    .fall_tick    (fall_tick),
    .glitch_count (glitch_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rises, falls, highs;
    rst = 1'b1; raw_in = 1'b0; clear_glitch = 1'b0;
    step(); step();
    chk("rst_db",     32'(db_level), 0);
    chk("rst_rise",   32'(rise_tick), 0);
    chk("rst_fall",   32'(fall_tick), 0);
    chk("rst_glitch", 32'(glitch_count), 0);
    chk("rst_busy",   32'(busy), 0);
    rst = 1'b0;
    step(); step(); step();

    // Clean rise, held 20 cycles.
    raw_in = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      chk("rise_db",   32'(db_level),  32'(e >= 7));
      chk("rise_busy", 32'(busy),      32'(e >= 3 && e <= 6));
      chk("rise_tick", 32'(rise_tick), 32'(e == 7));
      chk("rise_fall", 32'(fall_tick), 0);
    end
    chk("rise_glitch", 32'(glitch_count), 0);

    // Clean fall.
    raw_in = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk("fall_db",   32'(db_level),  32'(e < 7));
      chk("fall_busy", 32'(busy),      32'(e >= 3 && e <= 6));
      chk("fall_tick", 32'(fall_tick), 32'(e == 7));
    end

    // 4-cycle pulse: rejected, one glitch.
    raw_in = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 4) raw_in = 1'b0;
      chk("short_db",     32'(db_level),     0);
      chk("short_busy",   32'(busy),         32'(e >= 3 && e <= 6));
      chk("short_glitch", 32'(glitch_count), 32'(e >= 7));
      chk("short_rise",   32'(rise_tick),    0);
    end

    // 5-cycle pulse: accepted, then falls 7 edges after the drop.
    raw_in = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      if (e == 5) raw_in = 1'b0;
      chk("p5_db",     32'(db_level),  32'(e >= 7 && e < 12));
      chk("p5_rise",   32'(rise_tick), 32'(e == 7));
      chk("p5_fall",   32'(fall_tick), 32'(e == 12));
      chk("p5_busy",   32'(busy),      32'((e >= 3 && e <= 6) || (e >= 8 && e <= 11)));
      chk("p5_glitch", 32'(glitch_count), 1);
    end

    // Clear alone.
    clear_glitch = 1'b1;
    step();
    clear_glitch = 1'b0;
    chk("clear_only", 32'(glitch_count), 0);

    // Bring db_level high, then bounce on release: L H L H L H L H L H, then low.
    raw_in = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("bounce_pre_db", 32'(db_level), 1);
    falls = 0;
    raw_in = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      step();
      raw_in = ((e + 1) <= 10) ? ((e + 1) % 2 == 0) : 1'b0;
      if (fall_tick) falls++;
      chk("bounce_db",   32'(db_level),  32'(e < 17));
      chk("bounce_rise", 32'(rise_tick), 0);
    end
    chk("bounce_falls",  32'(falls), 1);
    chk("bounce_glitch", 32'(glitch_count), 5);

    // Saturation: toggle every cycle, ~300 aborts into an 8-bit counter.
    for (int c = 1; c <= 600; c++) begin
      raw_in = c[0];
      step();
    end
    raw_in = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("sat_value", 32'(glitch_count), 32'hFF);
    chk("sat_db",    32'(db_level), 0);

    // Clear coincident with an abort: abort happens at edge 4.
    raw_in = 1'b1;
    step();
    raw_in = 1'b0;
    step(); step();
    chk("clrab_busy", 32'(busy), 1);
    chk("clrab_pre",  32'(glitch_count), 32'hFF);
    clear_glitch = 1'b1;
    step();
    clear_glitch = 1'b0;
    chk("clrab_val",  32'(glitch_count), 0);
    chk("clrab_busy2", 32'(busy), 0);
    for (int i = 0; i < 4; i++) step();

    // Put one glitch on the counter, then reset mid-timing.
    raw_in = 1'b1; step(); raw_in = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_glitch", 32'(glitch_count), 1);
    raw_in = 1'b1;
    for (int e = 1; e <= 4; e++) step();
    chk("midrst_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy0",   32'(busy), 0);
    chk("midrst_db",      32'(db_level), 0);
    chk("midrst_glitch",  32'(glitch_count), 0);
    chk("midrst_rise",    32'(rise_tick), 0);
    step(); step();
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk("postrst_db",   32'(db_level),  32'(e >= 7));
      chk("postrst_rise", 32'(rise_tick), 32'(e == 7));
    end
    chk("postrst_glitch", 32'(glitch_count), 0);

    // Settle low, then a clean 30-cycle pulse.
    raw_in = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("pre30_db", 32'(db_level), 0);
    rises = 0; falls = 0; highs = 0;
    raw_in = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      step();
      if (e == 30) raw_in = 1'b0;
      if (rise_tick) rises++;
      if (fall_tick) falls++;
      if (db_level)  highs++;
      chk("p30_excl", 32'(rise_tick & fall_tick), 0);
    end
    chk("p30_rises",  32'(rises), 1);
    chk("p30_falls",  32'(falls), 1);
    chk("p30_width",  32'(highs), 30);
    chk("p30_glitch", 32'(glitch_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
